hazard_scoreboard: RTL and testbench

//   Load-use and long-latency hazard controller for the in-order pipeline.

---
 rtl/hazard_scoreboard.sv | 106 ++++++++++
 tb/tb_hazard_scoreboard.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Load-use and long-latency hazard controller for the in-order pipeline.
//   It keeps a countdown per architectural register for results that are
//   still in flight. Each cycle it decides whether the instruction in ID may
//   issue into Id_Rr, or must stall and inject a bubble.
//
// Ports
//   clk        pipeline clock, rising edge
//   reset      asynchronous reset, active low
//   id_valid   ID holds a valid instruction
//   rs, rt     source registers of the ID instruction
//   use_rs/rt  ID instruction reads rs / rt
//   dest       destination register (post RegDst mux)
//   reg_write  ID instruction writes dest
//   mem_read   ID instruction is a load
//   flush      squash the ID instruction (branch/jump redirect)
//   freeze     whole pipeline held (external memory wait)
//   stall      hold PC, IF/ID and Id_Rr
//   bubble     next stage loads a NOP this cycle
//   issue      ID instruction advances this cycle
//   busy       any scoreboard counter non-zero
//   stall_cnt  saturating count of hazard stall cycles
module hazard_scoreboard #(
    parameter int unsigned ALU_LAT  = 0,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic        use_rs,
    input  logic        use_rt,
    input  logic [4:0]  dest,
    input  logic        reg_write,
    input  logic        mem_read,
    input  logic        flush,
    input  logic        freeze,
    output logic        stall,
    output logic        bubble,
    output logic        issue,
    output logic        busy,
    output logic [15:0] stall_cnt
);

    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic [15:0]      stall_cnt_q;
    logic [15:0]      stall_cnt_d;
    logic             hazard;
    logic [CNT_W-1:0] lat;

    // Hazard check uses the pre-issue counters, so an instruction that reads
    // and writes the same register never waits on itself.
    always_comb begin
        hazard = id_valid &&
                 ((use_rs && (rs != 5'd0) && (cnt_q[rs] != '0)) ||
                  (use_rt && (rt != 5'd0) && (cnt_q[rt] != '0)));
        stall  = hazard && !flush;
        bubble = stall && !freeze;
        issue  = id_valid && !hazard && !flush && !freeze;
        busy   = 1'b0;
        for (int unsigned i = 1; i < 32; i++) begin
            if (cnt_q[i] != '0) busy = 1'b1;
        end
    end

    assign lat       = mem_read ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        for (int unsigned i = 0; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        stall_cnt_d = stall_cnt_q;
        if (!freeze) begin
            for (int unsigned i = 1; i < 32; i++) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(cnt_q[i] != '0);
            end
            // Issued write overrides the plain decrement; WAW keeps the longer wait.
            if (issue && reg_write && (dest != 5'd0)) begin
                if (lat > cnt_d[dest]) cnt_d[dest] = lat;
            end
            if (stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard. Three instances: 0 uses the default
// latencies, 1 uses LOAD_LAT=3, 2 uses LOAD_LAT=7 for stall_cnt saturation.
// Drivers push expected responses into a queue; a negedge monitor pops them
// and compares against the addressed instance.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n     [3];
    logic        id_valid  [3];
    logic [4:0]  rs        [3];
    logic [4:0]  rt        [3];
    logic        use_rs    [3];
    logic        use_rt    [3];
    logic [4:0]  dest      [3];
    logic        reg_write [3];
    logic        mem_read  [3];
    logic        flush     [3];
    logic        freeze    [3];
    logic        stall     [3];
    logic        bubble    [3];
    logic        issue     [3];
    logic        busy      [3];
    logic [15:0] scnt      [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned LL = (g == 0) ? 1 : ((g == 1) ? 3 : 7);
        hazard_scoreboard #(.ALU_LAT(0), .LOAD_LAT(LL), .CNT_W(3)) u_dut (
            .clk       (clk),
            .reset     (rst_n[g]),
            .id_valid  (id_valid[g]),
            .rs        (rs[g]),
            .rt        (rt[g]),
            .use_rs    (use_rs[g]),
            .use_rt    (use_rt[g]),
            .dest      (dest[g]),
            .reg_write (reg_write[g]),
            .mem_read  (mem_read[g]),
            .flush     (flush[g]),
            .freeze    (freeze[g]),
            .stall     (stall[g]),
            .bubble    (bubble[g]),
            .issue     (issue[g]),
            .busy      (busy[g]),
            .stall_cnt (scnt[g])
        );
    end

    typedef struct {
        int          inst;
        string       name;
        logic        st;
        logic        bu;
        logic        is;
        logic        chk_is;
        logic        by;
        logic [15:0] sc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check1(input string nm, input string fld,
                          input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s.%s: got %h required %h", nm, fld, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so compare mid-cycle.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check1(e.name, "stall",  16'(stall[e.inst]),  16'(e.st));
            check1(e.name, "bubble", 16'(bubble[e.inst]), 16'(e.bu));
            if (e.chk_is) check1(e.name, "issue", 16'(issue[e.inst]), 16'(e.is));
            check1(e.name, "busy",   16'(busy[e.inst]),   16'(e.by));
            check1(e.name, "stall_cnt", scnt[e.inst], e.sc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int n, input logic v,
                       input logic [4:0] s, input logic us,
                       input logic [4:0] t, input logic ut,
                       input logic [4:0] d, input logic rw, input logic mr,
                       input logic fl, input logic fz);
        id_valid[n] = v;  rs[n] = s;  use_rs[n] = us;  rt[n] = t;  use_rt[n] = ut;
        dest[n] = d;  reg_write[n] = rw;  mem_read[n] = mr;
        flush[n] = fl;  freeze[n] = fz;
    endtask

    task automatic idle(input int n);
        drv(n, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ex(input int n, input string nm, input logic st, input logic bu,
                      input logic is, input logic by, input logic [15:0] sc);
        exp_t e;
        e.inst = n; e.name = nm; e.st = st; e.bu = bu; e.is = is;
        e.chk_is = 1'b1; e.by = by; e.sc = sc;
        q.push_back(e);
    endtask

    task automatic ex_noissue(input int n, input string nm, input logic st,
                              input logic bu, input logic by, input logic [15:0] sc);
        exp_t e;
        e.inst = n; e.name = nm; e.st = st; e.bu = bu; e.is = 1'b0;
        e.chk_is = 1'b0; e.by = by; e.sc = sc;
        q.push_back(e);
    endtask

    task automatic run_inst0();
        // lw $8 then add $9,$8,$8
        step(); drv(0, 1, 0, 0, 0, 0, 8, 1, 1, 0, 0); ex(0, "lw8",          0, 0, 1, 0, 0);
        step(); drv(0, 1, 8, 1, 8, 1, 9, 1, 0, 0, 0); ex(0, "ld_use_stall", 1, 1, 0, 1, 0);
        step();                                       ex(0, "ld_use_issue", 0, 0, 1, 0, 1);
        step(); idle(0);                              ex(0, "alu_idle",     0, 0, 0, 0, 1);
        // ALU producer then consumer
        step(); drv(0, 1, 0, 0, 0, 0, 8, 1, 0, 0, 0); ex(0, "add8",         0, 0, 1, 0, 1);
        step(); drv(0, 1, 8, 1, 0, 0, 10, 1, 0, 0, 0); ex(0, "alu_no_stall", 0, 0, 1, 0, 1);
        // lw $8,($8): never stalls on itself, but does on its predecessor
        step(); drv(0, 1, 8, 1, 0, 0, 8, 1, 1, 0, 0); ex(0, "self_first",   0, 0, 1, 0, 1);
        step();                                       ex(0, "self_stall",   1, 1, 0, 1, 1);
        step();                                       ex(0, "self_issue",   0, 0, 1, 0, 2);
        step(); idle(0);                              ex(0, "self_busy",    0, 0, 0, 1, 2);
        step();                                       ex(0, "self_clear",   0, 0, 0, 0, 2);
        // freeze during a load-use stall
        step(); drv(0, 1, 0, 0, 0, 0, 8, 1, 1, 0, 0); ex(0, "fz_lw8",       0, 0, 1, 0, 2);
        for (int i = 0; i < 4; i++) begin
            step(); drv(0, 1, 8, 1, 0, 0, 9, 1, 0, 0, 1); ex(0, "freeze_hold", 1, 0, 0, 1, 2);
        end
        step(); freeze[0] = 1'b0;                     ex(0, "fz_release",   1, 1, 0, 1, 2);
        step();                                       ex(0, "fz_issue",     0, 0, 1, 0, 3);
        // $0 is never tracked
        step(); drv(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0); ex(0, "lw_r0",        0, 0, 1, 0, 3);
        step(); drv(0, 1, 0, 1, 0, 1, 9, 1, 0, 0, 0); ex(0, "r0_no_stall",  0, 0, 1, 0, 3);
        // flush wins over hazard and writes nothing
        step(); drv(0, 1, 0, 0, 0, 0, 8, 1, 1, 0, 0); ex(0, "fl_lw8",       0, 0, 1, 0, 3);
        step(); drv(0, 1, 8, 1, 0, 0, 10, 1, 1, 1, 0); ex(0, "flush",       0, 0, 0, 1, 3);
        step(); idle(0);                              ex(0, "flush_no_wr",  0, 0, 0, 0, 3);
    endtask

    task automatic run_inst1();
        // LOAD_LAT=3: lw $5, nop, consumer of $5 stalls 2 cycles
        step(); drv(1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0); ex(1, "l3_lw5",       0, 0, 1, 0, 0);
        step(); idle(1);                              ex(1, "l3_nop",       0, 0, 0, 1, 0);
        step(); drv(1, 1, 0, 0, 5, 1, 6, 1, 0, 0, 0); ex(1, "l3_stall1",    1, 1, 0, 1, 0);
        step();                                       ex(1, "l3_stall2",    1, 1, 0, 1, 1);
        step();                                       ex(1, "l3_issue",     0, 0, 1, 0, 2);
        step(); idle(1);                              ex(1, "l3_idle",      0, 0, 0, 0, 2);
        // async reset in the middle of a stall
        step(); drv(1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0); ex(1, "rs_lw5",       0, 0, 1, 0, 2);
        step(); drv(1, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0); ex(1, "rs_stall1",    1, 1, 0, 1, 2);
        step();                                       ex(1, "rs_stall2",    1, 1, 0, 1, 3);
        step(); rst_n[1] = 1'b0;                      ex_noissue(1, "reset_mid_stall", 0, 0, 0, 0);
        step(); rst_n[1] = 1'b1; idle(1);             ex(1, "post_reset",   0, 0, 0, 0, 0);
    endtask

    // lw $8,($8) held in ID: with LOAD_LAT=7 every eighth cycle issues,
    // the other seven stall.
    task automatic run_inst2();
        step(); drv(2, 1, 8, 1, 0, 0, 8, 1, 1, 0, 0); ex(2, "sat_k0",   0, 0, 1, 0, 0);
        repeat (800) step();                          ex(2, "sat_k800", 0, 0, 1, 0, 16'd700);
        repeat (74200) step();                        ex(2, "sat_full", 0, 0, 1, 0, 16'hFFFF);
        step();                                       ex(2, "sat_hold", 1, 1, 0, 1, 16'hFFFF);
        step(); idle(2);
    endtask

    initial begin
        for (int n = 0; n < 3; n++) begin
            rst_n[n] = 1'b0;
            idle(n);
        end
        step();
        for (int n = 0; n < 3; n++) ex(n, "reset_state", 0, 0, 0, 0, 0);
        step();
        for (int n = 0; n < 3; n++) rst_n[n] = 1'b1;
        fork
            begin run_inst0(); run_inst1(); end
            run_inst2();
        join
        @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
